sc4_fft_ctrl: RTL and testbench

- Sequencer for the 4-point serial-commutator FFT datapath (2 samples/beat, 4 beats/frame, 8 samples).
- Generates the commutator/butterfly selects s0..s3 from a beat-phase pipeline.
- Accepts framed input beats and flags output beats, so upstream/downstream logic never hand-drives selects.
- Sits between the sample source and the SC 4-point datapath; one instance per datapath.

---
 rtl/sc4_fft_ctrl.sv | 179 +++++++++++++++++
 tb/tb_sc4_fft_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sc4_fft_ctrl.sv
// ---------------------------------------------------------------------------
// sc4_fft_ctrl
//
// Sequencer for the 4-point serial-commutator FFT datapath. The datapath
// takes 2 samples per beat and 4 beats per frame. This block tracks the
// frame phase of every beat. It carries a {valid, phase} token for each
// cycle down a tap line, and from those tokens it derives the commutator and
// butterfly selects and the output beat flags. Upstream and downstream logic
// therefore never drive the selects themselves.
//
// Parameters
//   LAT     beats from the first input beat (k=0) to the first output beat
//           (legal 5..8)
//   S2_DLY  beat delay of the stage-2 select relative to stage 0
//   S3_DLY  beat delay of the stage-3 select relative to stage 0
//           (S2_DLY < S3_DLY < LAT)
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   input beat present on the datapath inputs this cycle
//   in_sof     in   first beat of a frame (qualified by in_valid)
//   s0..s3     out  stage selects (1 while the tap carries no valid token)
//   out_valid  out  datapath outputs hold a valid result beat
//   out_sof    out  first output beat of a frame
//   frame_err  out  one-cycle pulse on a protocol violation
//   busy       out  any token in flight
//
// Optional feature (macro SC4_FRAME_CNT_EN)
//   frame_cnt  out  16-bit count of output frames, wraps
//   err_cnt    out  8-bit count of frame_err pulses, saturates at 0xFF
// ---------------------------------------------------------------------------
module sc4_fft_ctrl #(
  parameter int LAT    = 5,
  parameter int S2_DLY = 2,
  parameter int S3_DLY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sof,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        s3,
  output logic        out_valid,
  output logic        out_sof,
  output logic        frame_err,
`ifdef SC4_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
`endif
  output logic        busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [1:0] phase;

  logic       start_beat;
  logic       cur_v;
  logic [1:0] cur_ph;

  // Registered token history. Entry d holds the token of the beat d cycles ago.
  logic       v_pipe  [1:LAT];
  logic [1:0] ph_pipe [1:LAT];

  // All taps, where tap 0 is the live token of the current beat.
  logic       tap_v  [0:LAT];
  logic [1:0] tap_ph [0:LAT];

  // Phase 0 is always handled in IDLE. An sof beat in IDLE opens a frame,
  // and RUN covers phases 1..3 only. This makes back-to-back frames
  // bubble-free, because the beat after phase 3 is judged exactly like
  // an idle beat.
  // rst gates the live token so selects and flags read idle immediately.
  always_comb begin
    start_beat = !rst && (state == IDLE) && in_valid && in_sof;
    cur_v      = !rst && ((state == RUN) || start_beat);
    cur_ph     = (state == RUN) ? phase : 2'd0;
    frame_err  = !rst &&
                 (((state == RUN)  && (!in_valid || in_sof)) ||
                  ((state == IDLE) &&  in_valid && !in_sof));
  end

  // Frame sequencer. The phase advances every cycle in RUN whether or not a
  // beat arrives, so the frame length is fixed at four beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_beat) begin
            state <= RUN;
            phase <= 2'd1;
          end
        end
        RUN: begin
          if (phase == 2'd3) begin
            state <= IDLE;
            phase <= 2'd0;
          end else begin
            phase <= phase + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          phase <= 2'd0;
        end
      endcase
    end
  end

  // Token shift line. One entry is shifted per cycle. The line is only as
  // deep as the furthest consumer (tap LAT), so busy falls as the last
  // output beat leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= LAT; i++) begin
        v_pipe[i]  <= 1'b0;
        ph_pipe[i] <= 2'd0;
      end
    end else begin
      v_pipe[1]  <= cur_v;
      ph_pipe[1] <= cur_ph;
      for (int i = 2; i <= LAT; i++) begin
        v_pipe[i]  <= v_pipe[i-1];
        ph_pipe[i] <= ph_pipe[i-1];
      end
    end
  end

  always_comb begin
    tap_v[0]  = cur_v;
    tap_ph[0] = cur_ph;
    for (int i = 1; i <= LAT; i++) begin
      tap_v[i]  = v_pipe[i];
      tap_ph[i] = ph_pipe[i];
    end
  end

  // Each select reads its own tap. An empty tap forces the select to 1.
  always_comb begin
    s0        = tap_v[0]      ? ~tap_ph[0][0]      : 1'b1;
    s1        = tap_v[0]      ? ~tap_ph[0][1]      : 1'b1;
    s2        = tap_v[S2_DLY] ? ~tap_ph[S2_DLY][1] : 1'b1;
    s3        = tap_v[S3_DLY] ? ~tap_ph[S3_DLY][0] : 1'b1;
    out_valid = tap_v[LAT];
    out_sof   = tap_v[LAT] && (tap_ph[LAT] == 2'd0);
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i <= LAT; i++) begin
      busy = busy | tap_v[i];
    end
  end

`ifdef SC4_FRAME_CNT_EN
  // Frame counter wraps naturally. The error counter holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 8'd0;
    end else begin
      if (out_valid && out_sof) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (frame_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sc4_fft_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sc4_fft_ctrl
//
// Scoreboard bench for sc4_fft_ctrl. The driver applies one beat per cycle.
// For each beat it works out the position of that beat within its frame
// (0..3, or -1 when there is no frame), using the framing rules. From the
// recent history of positions it derives the expected selects and flags,
// then queues that expectation. A monitor on the falling edge pops one
// expectation per driven cycle and compares it with the design.
// ---------------------------------------------------------------------------
module tb_sc4_fft_ctrl;

  localparam int LAT    = 5;
  localparam int S2_DLY = 2;
  localparam int S3_DLY = 4;

  logic clk      = 1'b0;
  logic rst      = 1'b1;
  logic in_valid = 1'b0;
  logic in_sof   = 1'b0;
  logic s0, s1, s2, s3, out_valid, out_sof, frame_err, busy;
`ifdef SC4_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  sc4_fft_ctrl #(.LAT(LAT), .S2_DLY(S2_DLY), .S3_DLY(S3_DLY)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .s0        (s0),
    .s1        (s1),
    .s2        (s2),
    .s3        (s3),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .frame_err (frame_err),
`ifdef SC4_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] sel;
    logic       ov;
    logic       os;
    logic       fe;
    logic       bz;
  } exp_t;

  exp_t expQ[$];
  int   hist[$];
  int   errors = 0;
  int   checks = 0;
  int   modelFrames = 0;
  int   modelErrs   = 0;

  // A position p means the beat is sample pair p of a frame, and -1 means
  // there is no frame. Stages 0/3 alternate on bit 0 and stages 1/2 follow
  // bit 1, so a select is the inverse of that bit, or 1 with no frame.
  function automatic logic selOf(input int p, input int b);
    if (p < 0) return 1'b1;
    return (((p >> b) & 1) == 0);
  endfunction

  task automatic applyStimulus(input logic v, input logic s, input logic r);
    int   prev;
    int   pos;
    logic anyFrame;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    in_sof   = s;
    rst      = r;
    prev = hist[0];
    if (r) begin
      pos = -1;
      for (int i = 0; i < hist.size(); i++) hist[i] = -1;
    end else if (prev >= 0 && prev < 3) begin
      pos = prev + 1;
    end else if (v && s) begin
      pos = 0;
    end else begin
      pos = -1;
    end
    hist.push_front(pos);
    void'(hist.pop_back());
    e.fe = !r && (((pos >= 1) && (!v || s)) || ((pos < 0) && v && !s));
    e.sel = {selOf(hist[S3_DLY], 0), selOf(hist[S2_DLY], 1),
             selOf(hist[0], 1), selOf(hist[0], 0)};
    e.ov = (hist[LAT] >= 0);
    e.os = (hist[LAT] == 0);
    anyFrame = 1'b0;
    for (int i = 0; i <= LAT; i++) if (hist[i] >= 0) anyFrame = 1'b1;
    e.bz = anyFrame;
    if (r) begin
      modelFrames = 0;
      modelErrs   = 0;
    end else begin
      if (e.os) modelFrames++;
      if (e.fe && modelErrs < 255) modelErrs++;
    end
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [3:0] actSel;
    actSel = {s3, s2, s1, s0};
    checks++;
    if (actSel !== e.sel) begin
      errors++;
      $display("[TB] FAIL selects t=%0t got=%b want=%b", $time, actSel, e.sel);
    end
    checks++;
    if ({out_valid, out_sof} !== {e.ov, e.os}) begin
      errors++;
      $display("[TB] FAIL out_flags t=%0t got=%b%b want=%b%b", $time,
               out_valid, out_sof, e.ov, e.os);
    end
    checks++;
    if (frame_err !== e.fe) begin
      errors++;
      $display("[TB] FAIL frame_err t=%0t got=%b want=%b", $time, frame_err, e.fe);
    end
    checks++;
    if (busy !== e.bz) begin
      errors++;
      $display("[TB] FAIL busy t=%0t got=%b want=%b", $time, busy, e.bz);
    end
  endtask

  // Monitor that runs independently of the driver.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  task automatic goodFrame();
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i <= LAT; i++) hist.push_back(-1);

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);

    // Single frame
    goodFrame();
    idle(8);

    // Three back-to-back frames
    repeat (3) goodFrame();
    idle(8);

    // Gap at k=2
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(8);

    // Stray beat while idle, then an sof in the middle of a frame
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idle(8);

    // Reset at k=3, then a fresh frame
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    idle(2);
    goodFrame();
    idle(8);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      logic v, s, r;
      v = ($urandom_range(0, 9) != 0);
      s = v && ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 99) == 0);
      applyStimulus(v, s, r);
    end

    // Drain, then check the optional counters against the model
    idle(LAT + 3);
    @(posedge clk);
    #1;
`ifdef SC4_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'(modelFrames)) begin
      errors++;
      $display("[TB] FAIL frame_cnt got=%0d want=%0d", frame_cnt, modelFrames);
    end
    checks++;
    if (err_cnt !== 8'(modelErrs)) begin
      errors++;
      $display("[TB] FAIL err_cnt got=%0d want=%0d", err_cnt, modelErrs);
    end
`endif
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got=%0d want=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
